fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_unit_sync_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM encoding and constants for the fetch unit
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; push into a full FIFO is accepted when a pop happens in the same cycle
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end

    // Pointers and occupancy; flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp == LAST ? '0 : wp + 1'b1;
            if (do_pop)
                rp <= rp == LAST ? '0 : rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with bounded in-flight requests, redirect flush and stale-response draining
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        id_ready
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);

    state_t        state, state_next;
    logic [31:0]   fpc, fpc_next, head_pc;
    logic [CW-1:0] outstanding, out_next, stale, stale_next, buffered, pc_count;
    logic [63:0]   head;
    logic          hs, rsp, live, instr_empty, instr_full, pc_full, pc_empty;
    logic          unused_flags;

    assign imem_req_addr  = fpc;
    assign imem_req_valid = state == RUN && ({1'b0, outstanding} + {1'b0, buffered}) < LIM;
    assign hs             = imem_req_valid && imem_req_ready;
    assign rsp            = imem_rsp_valid && outstanding != '0;
    assign live           = rsp && state == RUN && !redirect_valid;
    assign if_valid       = !instr_empty;
    assign if_pc          = instr_empty ? '0 : head[63:32];
    assign if_instr       = instr_empty ? '0 : head[31:0];
    assign unused_flags   = ^{pc_full, pc_empty, pc_count, instr_full};

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) pc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs),
        .pop   (live),
        .flush (redirect_valid),
        .din   (fpc),
        .dout  (head_pc),
        .full  (pc_full),
        .empty (pc_empty),
        .count (pc_count)
    );

    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) instr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (live),
        .pop   (id_ready),
        .flush (redirect_valid),
        .din   ({head_pc, imem_rsp_data}),
        .dout  (head),
        .full  (instr_full),
        .empty (instr_empty),
        .count (buffered)
    );

    // Next-state: redirect wins over everything; every in-flight request at that point becomes stale.
    always_comb begin
        out_next   = outstanding + CW'(hs) - CW'(rsp);
        stale_next = redirect_valid ? out_next
                   : (state == DRAIN && rsp && stale != '0) ? stale - 1'b1 : stale;
        fpc_next   = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : hs ? fpc + 32'd4 : fpc;
        state_next = redirect_valid ? (out_next != '0 ? DRAIN : RUN)
                   : state == DRAIN ? (stale_next == '0 ? RUN : DRAIN) : RUN;
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fpc         <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else begin
            state       <= state_next;
            fpc         <= fpc_next;
            outstanding <= out_next;
            stale       <= stale_next;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a queue-based model of the fetch stream
module tb_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, imem_req_valid, imem_req_ready;
    logic        imem_rsp_valid, if_valid, id_ready;
    logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_pc, if_instr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] dq[$];
    logic [31:0] req_log[$];
    logic [31:0] dec_log[$];
    int          dec_cyc[$];
    int          n_chk, n_pass, cyc, stale_n, last_due, lat_lo, lat_hi, consumed;
    bit          boot;
    logic [31:0] exp_req;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input bit rst_v, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input bit idr, input bit spur);
        bit rsp, hs, exp_rv;
        int lat;
        reset          = rst_v;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        id_ready       = idr;
        rsp            = q.size() > 0 && q[0].due <= cyc;
        imem_rsp_valid = rsp || (spur && q.size() == 0);
        imem_rsp_data  = rsp ? word(q[0].addr) : $urandom;
        #1;
        if (rst_v) begin
            chk("rst_req_valid", 32'(imem_req_valid), 0);
            chk("rst_if_valid", 32'(if_valid), 0);
            chk("rst_if_pc", if_pc, 0);
            chk("rst_if_instr", if_instr, 0);
            q.delete();
            dq.delete();
            stale_n  = 0;
            boot     = 1;
            exp_req  = RPC;
            last_due = 0;
        end else begin
            exp_rv = !boot && stale_n == 0 && q.size() + dq.size() < DEPTH;
            hs     = exp_rv && rdy;
            chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            chk("if_valid", 32'(if_valid), 32'(dq.size() > 0));
            if (dq.size() > 0) begin
                chk("if_pc", if_pc, dq[0]);
                chk("if_instr", if_instr, word(dq[0]));
            end
            if (hs) begin
                chk("req_addr", imem_req_addr, exp_req);
                req_log.push_back(imem_req_addr);
            end
            if (if_valid && idr) begin
                consumed++;
                if (!redir) begin
                    dec_log.push_back(if_pc);
                    dec_cyc.push_back(cyc);
                end
            end
            if (dq.size() > 0 && idr && !redir)
                void'(dq.pop_front());
            if (rsp) begin
                if (stale_n > 0)
                    stale_n--;
                else if (!redir)
                    dq.push_back(q[0].addr);
                void'(q.pop_front());
            end
            if (hs) begin
                lat      = $urandom_range(lat_hi, lat_lo);
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due;
                q.push_back('{exp_req, last_due});
                exp_req += 4;
            end
            if (redir) begin
                dq.delete();
                stale_n = q.size();
                exp_req = rpc & ~32'h3;
            end
            boot = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n, input bit rdy, input bit idr);
        repeat (n) tick(0, 0, 0, rdy, idr, 0);
    endtask

    task automatic clear_logs();
        req_log.delete();
        dec_log.delete();
        dec_cyc.delete();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; stale_n = 0; last_due = 0; consumed = 0;
        lat_lo = 1; lat_hi = 1; boot = 1; exp_req = RPC;
        reset = 1; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0; id_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0;
        @(negedge clk);

        // Sequential fetch from reset with a spurious response during BOOT.
        tick(1, 0, 0, 1, 1, 0);
        tick(1, 0, 0, 1, 1, 0);
        clear_logs();
        tick(0, 0, 0, 1, 1, 1);
        run(10, 1, 1);
        chk("s1_nreq", 32'(req_log.size() >= 3), 1);
        chk("s1_ndec", 32'(dec_log.size() >= 2), 1);
        chk("s1_req0", req_log[0], 32'h0);
        chk("s1_req1", req_log[1], 32'h4);
        chk("s1_req2", req_log[2], 32'h8);
        chk("s1_dec0", dec_log[0], 32'h0);
        chk("s1_dec1", dec_log[1], 32'h4);
        chk("s1_consec", 32'(dec_cyc[1] - dec_cyc[0]), 1);

        // Decode stalled: at most DEPTH requests, nothing lost on resume.
        tick(1, 0, 0, 1, 0, 0);
        clear_logs();
        tick(0, 0, 0, 1, 0, 0);
        run(6, 1, 0);
        chk("s2_nreq", 32'(req_log.size()), 2);
        run(6, 1, 1);
        chk("s2_ndec", 32'(dec_log.size() >= 2), 1);
        chk("s2_dec0", dec_log[0], 32'h0);
        chk("s2_dec1", dec_log[1], 32'h4);

        // Redirect with two requests in flight.
        tick(1, 0, 0, 1, 1, 0);
        lat_lo = 3; lat_hi = 3;
        tick(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 10 && q.size() < 2; i++) tick(0, 0, 0, 1, 1, 0);
        chk("s3_inflight", 32'(q.size()), 2);
        tick(0, 1, 32'h100, 1, 1, 0);
        clear_logs();
        run(14, 1, 1);
        chk("s3_nreq", 32'(req_log.size() >= 2), 1);
        chk("s3_req0", req_log[0], 32'h100);
        chk("s3_req1", req_log[1], 32'h104);
        chk("s3_dec0", dec_log[0], 32'h100);

        // Redirect coinciding with a response, unaligned target.
        lat_lo = 1; lat_hi = 1;
        run(4, 1, 1);
        for (int i = 0; i < 10 && !(q.size() > 0 && q[0].due <= cyc); i++) tick(0, 0, 0, 1, 1, 0);
        tick(0, 1, 32'h203, 1, 1, 0);
        clear_logs();
        run(8, 1, 1);
        chk("s4_req0", req_log[0], 32'h200);
        chk("s4_dec0", dec_log[0], 32'h200);

        // Wrap of the fetch address.
        tick(0, 1, 32'hFFFF_FFFC, 1, 1, 0);
        clear_logs();
        run(10, 1, 1);
        chk("s5_req0", req_log[0], 32'hFFFF_FFFC);
        chk("s5_req1", req_log[1], 32'h0);
        chk("s5_dec0", dec_log[0], 32'hFFFF_FFFC);
        chk("s5_dec1", dec_log[1], 32'h0);

        // Reset mid-stream with two requests outstanding.
        lat_lo = 3; lat_hi = 3;
        run(3, 1, 1);
        for (int i = 0; i < 10 && q.size() < 2; i++) tick(0, 0, 0, 1, 1, 0);
        tick(1, 0, 0, 1, 1, 0);
        clear_logs();
        tick(0, 0, 0, 1, 1, 0);
        chk("s6_boot_nreq", 32'(req_log.size()), 0);
        run(8, 1, 1);
        chk("s6_req0", req_log[0], RPC);

        // Random traffic with variable latency, back-pressure, redirects and resets.
        lat_lo = 1; lat_hi = 4;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(999, 0);
            tick(r < 5, r >= 5 && r < 45, $urandom, $urandom_range(3, 0) != 0,
                 $urandom_range(9, 0) < 7, 0);
        end
        chk("progress", 32'(consumed > 200), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
